// File: rtl/vga_text_scan.sv
// 640x480@60 timing and text-cell address generator with a two-stage output pipeline
// matched to the text RAM and font ROM latencies. Optional blinking underline cursor: VGA_TEXT_CURSOR_EN.
module vga_text_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CHAR_W   = 9,
  parameter int CHAR_H   = 16,
  parameter int COLS     = 70,
  parameter int ROWS     = 30
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic [4:0]  cursor_row,
  input  logic [6:0]  cursor_col,
  output logic        cursor,
`endif
  output logic [11:0] text_addr,
  output logic [3:0]  height,
  output logic [3:0]  width,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  SX_LAST  = 4'(CHAR_W - 1);
  localparam logic [3:0]  SY_LAST  = 4'(CHAR_H - 1);
  localparam logic [6:0]  COLS_C   = 7'(COLS);
  localparam logic [5:0]  ROWS_C   = 6'(ROWS);
  localparam logic [11:0] ROW_STEP = 12'(COLS);

  // Stage 0 scan state; row is 6 bits because it keeps counting through vertical blanking
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [3:0]  sub_x_q, sub_x_d;
  logic [6:0]  col_q, col_d;
  logic [3:0]  sub_y_q, sub_y_d;
  logic [5:0]  row_q, row_d;
  logic [11:0] row_base_q, row_base_d;

  logic [3:0]  height_q, height_d;
  logic [3:0]  sub_x1_q, sub_x1_d;
  logic        in_text1_q, in_text1_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic [3:0]  width_q, width_d;
  logic        valid_q, valid_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;

  logic h_wrap_s, v_wrap_s, in_text_s, hs0_s, vs0_s;

  always_comb begin
    h_wrap_s   = (h_cnt_q == H_LAST);
    v_wrap_s   = h_wrap_s && (v_cnt_q == V_LAST);
    h_cnt_d    = h_wrap_s ? 10'd0 : h_cnt_q + 10'd1;
    sub_x_d    = sub_x_q;
    col_d      = col_q;
    v_cnt_d    = v_cnt_q;
    sub_y_d    = sub_y_q;
    row_d      = row_q;
    row_base_d = row_base_q;

    if (h_wrap_s) begin
      sub_x_d = 4'd0;
      col_d   = 7'd0;
    end else if (sub_x_q == SX_LAST) begin
      sub_x_d = 4'd0;
      col_d   = col_q + 7'd1;
    end else begin
      sub_x_d = sub_x_q + 4'd1;
    end

    // The frame wrap wins over a coincident cell-row step
    if (v_wrap_s) begin
      v_cnt_d    = 10'd0;
      sub_y_d    = 4'd0;
      row_d      = 6'd0;
      row_base_d = 12'd0;
    end else if (h_wrap_s) begin
      v_cnt_d = v_cnt_q + 10'd1;
      if (sub_y_q == SY_LAST) begin
        sub_y_d    = 4'd0;
        row_d      = row_q + 6'd1;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        sub_y_d = sub_y_q + 4'd1;
      end
    end else begin
      v_cnt_d = v_cnt_q;
    end

    in_text_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT) && (col_q < COLS_C) && (row_q < ROWS_C);
    hs0_s     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs0_s     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

    height_d   = sub_y_q;
    sub_x1_d   = sub_x_q;
    in_text1_d = in_text_s;
    hs1_d      = hs0_s;
    vs1_d      = vs0_s;
    width_d    = sub_x1_q;
    valid_d    = in_text1_q;
    hsync_d    = hs1_q;
    vsync_d    = vs1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q    <= 10'd0;
      v_cnt_q    <= 10'd0;
      sub_x_q    <= 4'd0;
      col_q      <= 7'd0;
      sub_y_q    <= 4'd0;
      row_q      <= 6'd0;
      row_base_q <= 12'd0;
      height_q   <= 4'd0;
      sub_x1_q   <= 4'd0;
      in_text1_q <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      width_q    <= 4'd0;
      valid_q    <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      sub_x_q    <= sub_x_d;
      col_q      <= col_d;
      sub_y_q    <= sub_y_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      height_q   <= height_d;
      sub_x1_q   <= sub_x1_d;
      in_text1_q <= in_text1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      width_q    <= width_d;
      valid_q    <= valid_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign text_addr   = in_text_s ? (row_base_q + {5'd0, col_q}) : 12'd0;
  assign frame_start = !rst && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign height      = height_q;
  assign width       = width_q;
  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

`ifdef VGA_TEXT_CURSOR_EN
  localparam logic [3:0] SY_UL = 4'(CHAR_H - 2);

  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       cur1_q, cur1_d;
  logic       cursor_q, cursor_d;

  // frame_cnt steps on the wrap edge, so the new count is visible on the frame_start cycle
  always_comb begin
    frame_cnt_d = v_wrap_s ? frame_cnt_q + 6'd1 : frame_cnt_q;
    cur1_d      = in_text_s && (row_q == {1'b0, cursor_row}) && (col_q == cursor_col) &&
                  (sub_y_q >= SY_UL) && frame_cnt_q[5];
    cursor_d    = cur1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 6'd0;
      cur1_q      <= 1'b0;
      cursor_q    <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      cur1_q      <= cur1_d;
      cursor_q    <= cursor_d;
    end
  end

  assign cursor = cursor_q;
`endif

endmodule
